// File: rtl/aes_stream_sequencer_if.sv
// Command/response handshake bundle for aes_stream_sequencer.
// The master side issues commands and takes responses; the sequencer is the slave.
interface aes_stream_sequencer_if #(
  parameter int KEY_W  = 256,
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_key_mode;
  logic [KEY_W-1:0]  cmd_data;
  logic [TAG_W-1:0]  cmd_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic [1:0]        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_key_mode, cmd_data, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key_mode, cmd_data, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/aes_stream_sequencer.sv
// Tagged command sequencer driving the AES KeyBus/CipherBus with a buffered response FIFO.
// Optional wait-state watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_stream_sequencer #(
  parameter int KEY_W       = 256,
  parameter int DATA_W      = 128,
  parameter int TAG_W       = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                       clk,
  input  logic                       resetN,
  aes_stream_sequencer_if.slave      bus,
  output logic [KEY_W-1:0]           key_i_key,
  output logic [1:0]                 key_i_key_mode,
  output logic                       key_i_start,
  input  logic                       key_o_key_ready,
  output logic [DATA_W-1:0]          cph_i_data,
  output logic                       cph_i_data_valid,
  output logic                       cph_i_ende,
  output logic                       cph_i_enable,
  input  logic                       cph_o_ready,
  input  logic                       cph_o_data_valid,
  input  logic [DATA_W-1:0]          cph_o_data,
  output logic                       busy,
  output logic                       key_loaded,
  output logic [$clog2(RSP_DEPTH):0] rsp_count
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [3:0] {
    IDLE, KEY_START, KEY_GAP, KEY_WAIT, DAT_RDY, DAT_ISSUE, DAT_GAP, DAT_WAIT, PUSH
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        cur_op;
  logic [TAG_W-1:0]  cur_tag;
  logic [DATA_W-1:0] res_data, res_data_nx;
  logic [1:0]        res_err, res_err_nx;
  logic              accept, fifo_push, fifo_pop, tmo_hit;

  logic [DATA_W-1:0] mem_data [RSP_DEPTH];
  logic [TAG_W-1:0]  mem_tag  [RSP_DEPTH];
  logic [1:0]        mem_err  [RSP_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  assign bus.cmd_ready    = (state == IDLE) && (rsp_count < CW'(RSP_DEPTH));
  assign accept           = bus.cmd_ready && bus.cmd_valid;
  assign key_i_start      = (state == KEY_START);
  assign cph_i_data_valid = (state == DAT_ISSUE);
  assign cph_i_enable     = key_loaded;
  assign busy             = (state != IDLE);
  assign fifo_push        = (state == PUSH);

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Counter restarts whenever the FSM moves, so it measures time spent in the current wait state.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      tmo_cnt <= '0;
    end else if (state_nx != state) begin
      tmo_cnt <= '0;
    end else if (state inside {KEY_WAIT, DAT_RDY, DAT_WAIT}) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    res_data_nx = res_data;
    res_err_nx  = res_err;
    unique case (state)
      IDLE:      if (accept) state_nx = (bus.cmd_op == 2'b10) ? KEY_START : DAT_RDY;
      KEY_START: state_nx = KEY_GAP;
      KEY_GAP:   state_nx = KEY_WAIT;
      KEY_WAIT: begin
        if (key_o_key_ready) begin
          state_nx    = PUSH;
          res_data_nx = '0;
          res_err_nx  = 2'b00;
        end else if (tmo_hit) begin
          state_nx    = PUSH;
          res_data_nx = '0;
          res_err_nx  = 2'b11;
        end
      end
      // Reserved op and missing key are both resolved here, before any bus activity.
      DAT_RDY: begin
        if (cur_op == 2'b11) begin
          state_nx    = PUSH;
          res_data_nx = '0;
          res_err_nx  = 2'b10;
        end else if (!key_loaded) begin
          state_nx    = PUSH;
          res_data_nx = '0;
          res_err_nx  = 2'b01;
        end else if (cph_o_ready) begin
          state_nx = DAT_ISSUE;
        end else if (tmo_hit) begin
          state_nx    = PUSH;
          res_data_nx = '0;
          res_err_nx  = 2'b11;
        end
      end
      DAT_ISSUE: state_nx = DAT_GAP;
      DAT_GAP:   state_nx = DAT_WAIT;
      DAT_WAIT: begin
        if (cph_o_data_valid) begin
          state_nx    = PUSH;
          res_data_nx = cph_o_data;
          res_err_nx  = 2'b00;
        end else if (tmo_hit) begin
          state_nx    = PUSH;
          res_data_nx = '0;
          res_err_nx  = 2'b11;
        end
      end
      PUSH:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus drive registers only change on accepted commands so they hold between operations.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cur_op         <= '0;
      cur_tag        <= '0;
      res_data       <= '0;
      res_err        <= '0;
      key_i_key      <= '0;
      key_i_key_mode <= '0;
      cph_i_data     <= '0;
      cph_i_ende     <= 1'b0;
      key_loaded     <= 1'b0;
    end else begin
      res_data <= res_data_nx;
      res_err  <= res_err_nx;
      if (accept) begin
        cur_op  <= bus.cmd_op;
        cur_tag <= bus.cmd_tag;
        if (bus.cmd_op == 2'b10) begin
          key_i_key      <= bus.cmd_data;
          key_i_key_mode <= bus.cmd_key_mode;
          key_loaded     <= 1'b0;
        end else if (!bus.cmd_op[1] && key_loaded) begin
          cph_i_data <= bus.cmd_data[DATA_W-1:0];
          cph_i_ende <= bus.cmd_op[0];
        end
      end
      if (state == KEY_WAIT && key_o_key_ready) key_loaded <= 1'b1;
    end
  end

  assign fifo_pop      = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_valid = (rsp_count != '0);
  assign bus.rsp_data  = bus.rsp_valid ? mem_data[rd_ptr] : '0;
  assign bus.rsp_tag   = bus.rsp_valid ? mem_tag[rd_ptr]  : '0;
  assign bus.rsp_err   = bus.rsp_valid ? mem_err[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_data[wr_ptr] <= res_data;
      mem_tag[wr_ptr]  <= cur_tag;
      mem_err[wr_ptr]  <= res_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      rsp_count <= rsp_count + 1'b1;
      else if (fifo_pop && !fifo_push) rsp_count <= rsp_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_stream_sequencer.sv
// Scoreboard bench for aes_stream_sequencer with emulated key-expansion and cipher cores.
// Defining AES_SEQ_TIMEOUT_EN also exercises the watchdog path.
module tb_aes_stream_sequencer;
  localparam int KEY_W  = 256;
  localparam int DATA_W = 128;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;
  localparam logic [KEY_W-1:0]  FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [DATA_W-1:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DATA_W-1:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        err;
  } rsp_t;

  logic clk = 1'b0;
  logic resetN;
  logic [KEY_W-1:0]  key_i_key;
  logic [1:0]        key_i_key_mode;
  logic              key_i_start, key_o_key_ready;
  logic [DATA_W-1:0] cph_i_data, cph_o_data;
  logic              cph_i_data_valid, cph_i_ende, cph_i_enable;
  logic              cph_o_ready, cph_o_data_valid;
  logic              busy, key_loaded;
  logic [$clog2(DEPTH):0] rsp_count;

  aes_stream_sequencer_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  aes_stream_sequencer #(
    .KEY_W(KEY_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .RSP_DEPTH(DEPTH), .TIMEOUT_CYC(40)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus),
    .key_i_key(key_i_key), .key_i_key_mode(key_i_key_mode), .key_i_start(key_i_start),
    .key_o_key_ready(key_o_key_ready),
    .cph_i_data(cph_i_data), .cph_i_data_valid(cph_i_data_valid), .cph_i_ende(cph_i_ende),
    .cph_i_enable(cph_i_enable), .cph_o_ready(cph_o_ready), .cph_o_data_valid(cph_o_data_valid),
    .cph_o_data(cph_o_data), .busy(busy), .key_loaded(key_loaded), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  rsp_t exp_q[$];
  logic [KEY_W-1:0] model_key = '0;
  logic [1:0]       model_mode = '0;
  logic             model_key_loaded = 1'b0;
  int exp_key_loads = 0, exp_cph_issues = 0, key_pulses = 0, cph_pulses = 0;
  logic hold_cipher = 1'b0, rsp_rand = 1'b0, rsp_ready_force = 1'b0;
  int fixed_key_dly = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the AES core: real FIPS-197 vector pair, otherwise a keyed invertible-looking scramble.
  function automatic logic [DATA_W-1:0] ref_cipher(input logic [KEY_W-1:0] k, input logic [1:0] m,
                                                   input logic [DATA_W-1:0] d, input logic e);
    logic [DATA_W-1:0] r;
    if (k == FIPS_KEY && m == 2'b10 && !e && d == PT) return CT;
    if (k == FIPS_KEY && m == 2'b10 && e && d == CT) return PT;
    r = e ? {d[0], d[DATA_W-1:1]} : d;
    return r ^ k[DATA_W-1:0] ^ k[KEY_W-1 -: DATA_W] ^ DATA_W'(m);
  endfunction

  function automatic logic [KEY_W-1:0] rnd_bits();
    logic [KEY_W-1:0] r;
    for (int i = 0; i < KEY_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] mode, input logic [KEY_W-1:0] data,
                          input logic [TAG_W-1:0] tag, output int acc_cyc);
    rsp_t e;
    int n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_key_mode = mode;
    bus.cmd_data = data; bus.cmd_tag = tag;
    while (n < 2000) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout actual=no_ready required=ready tag=%0h", tag);
      bus.cmd_valid = 1'b0;
      acc_cyc = cyc;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    e.tag = tag; e.err = 2'b00; e.data = '0;
    case (op)
      2'b10: begin model_key = data; model_mode = mode; model_key_loaded = 1'b1; exp_key_loads++; end
      2'b11: e.err = 2'b10;
      default: begin
        if (!model_key_loaded) e.err = 2'b01;
        else begin
          exp_cph_issues++;
          e.data = ref_cipher(model_key, model_mode, data[DATA_W-1:0], op[0]);
`ifdef AES_SEQ_TIMEOUT_EN
          if (hold_cipher) begin e.err = 2'b11; e.data = '0; end
`endif
        end
      end
    endcase
    exp_q.push_back(e);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rsp_count != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    check(name, DATA_W'(n >= 3000), '0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rsp_valid"}, DATA_W'(bus.rsp_valid), '0);
    check({pfx, "_rsp_count"}, DATA_W'(rsp_count), '0);
    check({pfx, "_key_loaded"}, DATA_W'(key_loaded), '0);
    check({pfx, "_busy"}, DATA_W'(busy), '0);
    check({pfx, "_bus_strobes"}, DATA_W'({key_i_start, cph_i_data_valid, cph_i_enable, cph_i_ende}), '0);
    check({pfx, "_cph_i_data"}, cph_i_data, '0);
    check({pfx, "_key_i_key"}, key_i_key[DATA_W-1:0], '0);
    check({pfx, "_rsp_data"}, bus.rsp_data, '0);
  endtask

  // Response monitor: pops the scoreboard on every completed response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (resetN && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected actual_tag=%0h required=none", bus.rsp_tag);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus.rsp_data !== e.data || bus.rsp_tag !== e.tag || bus.rsp_err !== e.err) begin
            failures++;
            $display("FAIL rsp actual=%0h/%0h/%0h required=%0h/%0h/%0h (data/tag/err)",
                     bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
          end
        end
      end
    end
  end

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = rsp_rand ? ($urandom_range(0, 2) != 0) : rsp_ready_force;
    end
  end

  // Key-expansion and cipher core emulation.
  initial begin
    logic s_rst, s_ks, s_dv, prev_ks, prev_dv, c_busy, e_ende;
    logic [KEY_W-1:0] e_key, junk;
    logic [1:0] e_mode;
    logic [DATA_W-1:0] e_data;
    int k_cnt, c_cnt;
    prev_ks = 1'b0; prev_dv = 1'b0; c_busy = 1'b0; k_cnt = 0; c_cnt = 0;
    e_key = '0; e_mode = '0; e_data = '0; e_ende = 1'b0;
    key_o_key_ready = 1'b0; cph_o_ready = 1'b0; cph_o_data_valid = 1'b0; cph_o_data = '0;
    forever begin
      @(negedge clk);
      s_rst = !resetN; s_ks = key_i_start; s_dv = cph_i_data_valid;
      if (s_ks) begin
        check("key_start_single_cycle", DATA_W'(prev_ks), '0);
        key_pulses++; e_key = key_i_key; e_mode = key_i_key_mode;
      end
      if (s_dv) begin
        check("cph_valid_single_cycle", DATA_W'(prev_dv), '0);
        cph_pulses++; e_data = cph_i_data; e_ende = cph_i_ende;
      end
      prev_ks = s_ks; prev_dv = s_dv;
      @(posedge clk); #1;
      if (s_rst) begin
        k_cnt = 0; c_busy = 1'b0;
        key_o_key_ready = 1'b0; cph_o_ready = 1'b0; cph_o_data_valid = 1'b0;
      end else begin
        if (s_ks) begin
          key_o_key_ready = 1'b0;
          k_cnt = (fixed_key_dly != 0) ? fixed_key_dly : $urandom_range(1, 16);
        end else if (k_cnt > 0) begin
          k_cnt--;
          if (k_cnt == 0) key_o_key_ready = 1'b1;
        end
        junk = rnd_bits();
        cph_o_data_valid = 1'b0;
        cph_o_data = junk[DATA_W-1:0];
        if (s_dv) begin
          c_busy = 1'b1; c_cnt = $urandom_range(1, 6); cph_o_ready = 1'b0;
        end else if (c_busy) begin
          if (!hold_cipher) begin
            c_cnt--;
            if (c_cnt == 0) begin
              cph_o_data_valid = 1'b1;
              cph_o_data = ref_cipher(e_key, e_mode, e_data, e_ende);
              c_busy = 1'b0;
            end
          end
        end else begin
          cph_o_ready = ($urandom_range(0, 3) != 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int acc, n, rel_cyc, r;
    logic [1:0] op;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_key_mode = '0; bus.cmd_data = '0; bus.cmd_tag = '0;
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 resetN = 1'b1;
    rsp_ready_force = 1'b1;
    repeat (3) @(posedge clk);

    // Errors before any key: T+3 response latency, no cipher activity.
    send_cmd(2'b00, 2'b00, {128'h0, PT}, 4'h5, acc);
    @(negedge clk); @(negedge clk);
    check("err01_rsp_early", DATA_W'(bus.rsp_valid), '0);
    @(negedge clk);
    check("err01_rsp_t3", DATA_W'(bus.rsp_valid), 1);
    wait_idle("err01_idle");
    send_cmd(2'b11, 2'b00, '0, 4'h6, acc);
    @(negedge clk); @(negedge clk);
    check("err10_rsp_early", DATA_W'(bus.rsp_valid), '0);
    @(negedge clk);
    check("err10_rsp_t3", DATA_W'(bus.rsp_valid), 1);
    wait_idle("err10_idle");
    check("no_cph_pulse_on_errors", DATA_W'(cph_pulses), '0);

    // FIPS key load with a 14-cycle expansion delay.
    fixed_key_dly = 14;
    send_cmd(2'b10, 2'b10, FIPS_KEY, 4'h1, acc);
    @(negedge clk);
    check("key_start_t1", DATA_W'(key_i_start), 1);
    @(negedge clk);
    check("key_start_t2", DATA_W'(key_i_start), '0);
    wait_idle("keyload_idle");
    fixed_key_dly = 0;
    check("key_loaded_after_load", DATA_W'({key_loaded, cph_i_enable}), 2'b11);

    send_cmd(2'b00, 2'b00, {128'h0, PT}, 4'h2, acc);
    wait_idle("encrypt_idle");
    check("encrypt_ende", DATA_W'(cph_i_ende), '0);
    send_cmd(2'b01, 2'b00, {128'h0, CT}, 4'h3, acc);
    wait_idle("decrypt_idle");
    check("decrypt_ende", DATA_W'(cph_i_ende), 1);

    // Back-pressure: four responses fill the FIFO, fifth waits for release.
    rsp_ready_force = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) send_cmd(2'b00, 2'b00, rnd_bits(), TAG_W'(8 + i), acc);
    n = 0;
    while (rsp_count != 4 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("full_rsp_count", DATA_W'(rsp_count), 4);
    check("full_cmd_ready", DATA_W'(bus.cmd_ready), '0);
    rel_cyc = 0;
    fork
      send_cmd(2'b01, 2'b00, rnd_bits(), 4'hC, acc);
      begin
        repeat (6) @(posedge clk);
        rel_cyc = cyc;
        #1 rsp_ready_force = 1'b1;
      end
    join
    check("fifth_after_release", DATA_W'(acc > rel_cyc), 1);
    wait_idle("full_drain");

`ifdef AES_SEQ_TIMEOUT_EN
    hold_cipher = 1'b1;
    send_cmd(2'b00, 2'b00, rnd_bits(), 4'hD, acc);
    wait_idle("timeout_idle");
    check("timeout_key_kept", DATA_W'(key_loaded), 1);
    hold_cipher = 1'b0;
    @(posedge clk); #1 resetN = 1'b0;
    @(posedge clk); #1 resetN = 1'b1;
    model_key_loaded = 1'b0;
    send_cmd(2'b10, 2'b01, rnd_bits(), 4'h1, acc);
    wait_idle("timeout_reload");
`endif

    // Reset while waiting for cipher output drops the command without a response.
    hold_cipher = 1'b1;
    n = cph_pulses;
    send_cmd(2'b00, 2'b00, rnd_bits(), 4'hE, acc);
    r = 0;
    while (cph_pulses == n && r < 200) begin @(negedge clk); r++; end
    check("rst_test_issue", DATA_W'(r >= 200), '0);
    repeat (3) @(posedge clk);
    check("rst_test_busy", DATA_W'(busy), 1);
    #1 resetN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    model_key_loaded = 1'b0;
    hold_cipher = 1'b0;
    @(posedge clk); #1 resetN = 1'b1;

    // Randomized traffic with random response back-pressure.
    rsp_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 15) ? 2'b10 : (r < 22) ? 2'b11 : (r < 61) ? 2'b00 : 2'b01;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_cmd(op, 2'($urandom_range(0, 3)), rnd_bits(), 4'($urandom_range(0, 15)), acc);
    end
    rsp_rand = 1'b0;
    rsp_ready_force = 1'b1;
    wait_idle("final_drain");
    check("key_start_pulses", DATA_W'(key_pulses), DATA_W'(exp_key_loads));
    check("cph_valid_pulses", DATA_W'(cph_pulses), DATA_W'(exp_cph_issues));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
